spsram_arbiter: RTL and testbench

Two-port round-robin arbiter sharing one single-port SRAM (`spsram`, DEPTH x WIDTH, one access per cycle, registered read data) between requesters A and B. Each port offers a valid/ready request channel and a fixed-latency read-response channel. The block sits between the two masters and the SRAM instance and drives its `cs/we/ad/din` pins directly. It adds no latency on the request side.

---
 rtl/spsram_arbiter.sv | 90 +++++++++
 tb/tb_spsram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spsram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between requesters A and B.
// Requests are granted combinationally; read data returns one cycle after acceptance.
module spsram_arbiter #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic                 a_we,
  input  logic [DEPTH_LOG-1:0] a_ad,
  input  logic [WIDTH-1:0]     a_din,
  output logic                 a_rvalid,
  output logic [WIDTH-1:0]     a_rdata,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic                 b_we,
  input  logic [DEPTH_LOG-1:0] b_ad,
  input  logic [WIDTH-1:0]     b_din,
  output logic                 b_rvalid,
  output logic [WIDTH-1:0]     b_rdata,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [DEPTH_LOG-1:0] sram_ad,
  output logic [WIDTH-1:0]     sram_din,
  input  logic [WIDTH-1:0]     sram_dout
);

  logic last;
  logic rd_pend;
  logic rd_id;
  logic gnt_a;
  logic gnt_b;

  // Request side: grant and SRAM drive, same cycle as the handshake
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      // On contention, last == B (1) hands the slot to A, otherwise to B.
      if (a_valid && (!b_valid || last)) begin
        gnt_a = 1'b1;
      end else if (b_valid) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign sram_cs = gnt_a | gnt_b;

  always_comb begin
    sram_we  = 1'b0;
    sram_ad  = '0;
    sram_din = '0;
    if (gnt_a) begin
      sram_we  = a_we;
      sram_ad  = a_ad;
      sram_din = a_din;
    end else if (gnt_b) begin
      sram_we  = b_we;
      sram_ad  = b_ad;
      sram_din = b_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else if (sram_cs) begin
      last    <= gnt_b;
      rd_pend <= ~sram_we;
      rd_id   <= gnt_b;
    end else begin
      rd_pend <= 1'b0;
    end
  end

  // Response side: SRAM registered data, steered by the issuing port
  assign a_rvalid = rd_pend & ~rd_id & ~rst;
  assign b_rvalid = rd_pend &  rd_id & ~rst;
  assign a_rdata  = sram_dout;
  assign b_rdata  = sram_dout;

endmodule

// File: tb/tb_spsram_arbiter.sv
// Bench for spsram_arbiter: behavioural SRAM, directed scenarios and a
// randomized run checked against a transaction-level reference model.
module tb_spsram_arbiter;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             preload;
  logic             a_valid, a_ready, a_we, a_rvalid;
  logic [AW-1:0]    a_ad;
  logic [WIDTH-1:0] a_din, a_rdata;
  logic             b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0]    b_ad;
  logic [WIDTH-1:0] b_din, b_rdata;
  logic             sram_cs, sram_we;
  logic [AW-1:0]    sram_ad;
  logic [WIDTH-1:0] sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  spsram_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEPTH_LOG(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_ad(a_ad), .a_din(a_din),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_ad(b_ad), .b_din(b_din),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_ad(sram_ad), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with registered read data; dout holds on writes
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
    end else if (sram_cs) begin
      if (sram_we) mem[sram_ad] <= sram_din;
      else         sram_dout    <= mem[sram_ad];
    end
  end

  // Reference model: who wins, what memory holds, what response is owed
  logic             m_last, m_pend, m_id;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_mem [DEPTH];

  function automatic int pick();
    if (rst) return -1;
    if (a_valid && b_valid) return m_last ? 0 : 1;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = pick();
    if (preload) for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'(i);
    if (rst) begin
      m_last <= 1'b1;
      m_pend <= 1'b0;
      m_id   <= 1'b0;
    end else if (w == 0) begin
      m_last <= 1'b0;
      m_id   <= 1'b0;
      m_pend <= !a_we;
      if (a_we) m_mem[a_ad] <= a_din;
      else      m_data      <= m_mem[a_ad];
    end else if (w == 1) begin
      m_last <= 1'b1;
      m_id   <= 1'b1;
      m_pend <= !b_we;
      if (b_we) m_mem[b_ad] <= b_din;
      else      m_data      <= m_mem[b_ad];
    end else begin
      m_pend <= 1'b0;
    end
  end

  task automatic idle();
    a_valid = 0; a_we = 0; a_ad = 0; a_din = 0;
    b_valid = 0; b_we = 0; b_ad = 0; b_din = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %0b expected 0", a_ready); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %0b expected 0", b_ready); end
      checks++; if (sram_cs !== 1'b0) begin errors++; $display("FAIL rst_cs: got %0b expected 0", sram_cs); end
      checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %0b%0b expected 00", a_rvalid, b_rvalid); end
      next();
    end
    rst = 0; preload = 0; idle();
  endtask

  task automatic test_single_read();
    a_valid = 1; a_ad = 5;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready: got %0b expected 1", a_ready); end
    checks++; if (sram_cs !== 1'b1 || sram_ad !== 3'd5) begin errors++; $display("FAIL single_sram: got cs=%0b ad=%0d expected cs=1 ad=5", sram_cs, sram_ad); end
    next(); idle();
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'd5) begin errors++; $display("FAIL single_resp: got rvalid=%0b rdata=%0h expected 1/5", a_rvalid, a_rdata); end
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL single_b_rvalid: got %0b expected 0", b_rvalid); end
    next();
  endtask

  task automatic test_contention();
    bit prev_a;
    rst = 1; idle(); next(); rst = 0;
    a_valid = 1; a_ad = 1; b_valid = 1; b_ad = 2;
    for (int i = 0; i <= 4; i++) begin
      if (i == 4) idle();
      @(negedge clk);
      if (i < 4) begin
        checks++; if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d: got a=%0b b=%0b expected %s", i, a_ready, b_ready, (i % 2 == 0) ? "A" : "B"); end
      end
      if (i > 0) begin
        checks++; if (a_rvalid !== prev_a || b_rvalid !== !prev_a || a_rdata !== (prev_a ? 32'd1 : 32'd2)) begin errors++; $display("FAIL rr_resp%0d: got a=%0b b=%0b data=%0h expected from %s", i, a_rvalid, b_rvalid, a_rdata, prev_a ? "A" : "B"); end
      end
      prev_a = (i % 2 == 0);
      next();
    end
  endtask

  task automatic test_write_then_read();
    b_valid = 1; b_we = 1; b_ad = 3; b_din = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (b_ready !== 1'b1 || sram_we !== 1'b1 || sram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_drive: got ready=%0b we=%0b din=%0h expected 1/1/deadbeef", b_ready, sram_we, sram_din); end
    next(); b_we = 0;
    @(negedge clk);
    checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin errors++; $display("FAIL wr_no_resp: got %0b%0b expected 00", a_rvalid, b_rvalid); end
    next(); idle();
    @(negedge clk);
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_resp: got rvalid=%0b rdata=%0h expected 1/deadbeef", b_rvalid, b_rdata); end
    next();
  endtask

  task automatic test_read_then_write();
    a_valid = 1; a_ad = 7;
    next(); idle();
    b_valid = 1; b_we = 1; b_ad = 7; b_din = 32'h12345678;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'd7) begin errors++; $display("FAIL war_resp: got rvalid=%0b rdata=%0h expected 1/7", a_rvalid, a_rdata); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL war_b_ready: got %0b expected 1", b_ready); end
    next(); idle();
    a_valid = 1; a_ad = 7;
    next(); idle();
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h12345678) begin errors++; $display("FAIL war_reread: got rvalid=%0b rdata=%0h expected 1/12345678", a_rvalid, a_rdata); end
    next();
  endtask

  task automatic test_reset_mid();
    a_valid = 1; a_ad = 4;
    next(); idle(); rst = 1;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_in: got %0b expected 0", a_rvalid); end
    next(); rst = 0;
    a_valid = 1; a_ad = 1; b_valid = 1; b_ad = 2;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_after: got %0b expected 0", a_rvalid); end
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL midrst_grant: got a=%0b b=%0b expected A", a_ready, b_ready); end
    next(); idle();
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'd1) begin errors++; $display("FAIL midrst_resp: got rvalid=%0b rdata=%0h expected 1/1", a_rvalid, a_rdata); end
    next();
  endtask

  task automatic test_only_b();
    logic [AW-1:0] prev_ad;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin b_valid = 1; b_ad = AW'($urandom_range(0, 2)); end
      else idle();
      @(negedge clk);
      if (i < 3) begin
        checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL onlyb_grant%0d: got a=%0b b=%0b expected B", i, a_ready, b_ready); end
      end
      if (i > 0) begin
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'(prev_ad)) begin errors++; $display("FAIL onlyb_resp%0d: got rvalid=%0b rdata=%0h expected 1/%0h", i, b_rvalid, b_rdata, prev_ad); end
      end
      prev_ad = b_ad;
      next();
    end
  endtask

  task automatic test_random();
    bit a_hold = 0, b_hold = 0;
    int w;
    logic [WIDTH-1:0] exp_din;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!a_hold) begin
        a_valid = $urandom_range(0, 1); a_we = $urandom_range(0, 2) == 0;
        a_ad = AW'($urandom_range(0, DEPTH - 1)); a_din = $urandom;
      end
      if (!b_hold) begin
        b_valid = $urandom_range(0, 1); b_we = $urandom_range(0, 2) == 0;
        b_ad = AW'($urandom_range(0, DEPTH - 1)); b_din = $urandom;
      end
      @(negedge clk);
      w = pick();
      exp_din = (w == 0 && a_we) ? a_din : (w == 1 && b_we) ? b_din : '0;
      checks++; if (a_ready !== (w == 0) || b_ready !== (w == 1)) begin errors++; $display("FAIL rnd_grant%0d: got a=%0b b=%0b expected winner %0d", i, a_ready, b_ready, w); end
      checks++; if (sram_cs !== (w >= 0) || sram_we !== ((w == 0) ? a_we : (w == 1) ? b_we : 1'b0)) begin errors++; $display("FAIL rnd_cs_we%0d: got cs=%0b we=%0b winner %0d", i, sram_cs, sram_we, w); end
      checks++; if (sram_ad !== ((w == 0) ? a_ad : (w == 1) ? b_ad : 3'd0)) begin errors++; $display("FAIL rnd_ad%0d: got %0d winner %0d", i, sram_ad, w); end
      if (w >= 0 && sram_we) begin
        checks++; if (sram_din !== exp_din) begin errors++; $display("FAIL rnd_din%0d: got %0h expected %0h", i, sram_din, exp_din); end
      end
      checks++; if (a_rvalid !== (m_pend && !m_id && !rst) || b_rvalid !== (m_pend && m_id && !rst)) begin errors++; $display("FAIL rnd_rvalid%0d: got a=%0b b=%0b expected pend=%0b id=%0b", i, a_rvalid, b_rvalid, m_pend && !rst, m_id); end
      if (m_pend && !rst) begin
        checks++; if (a_rdata !== m_data) begin errors++; $display("FAIL rnd_rdata%0d: got %0h expected %0h", i, a_rdata, m_data); end
      end
      a_hold = a_valid && (w != 0);
      b_hold = b_valid && (w != 1);
      next();
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1; preload = 1; idle();
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_read_then_write();
    test_reset_mid();
    test_only_b();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
